// File: rtl/dm_responder.sv
// Data-memory responder for the core's MEM stage: byte-laned word RAM with same-cycle loads,
// sign/zero extension, misalignment detection and a 16-byte MMIO window.
module dm_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_w,
   input  logic [31:0] Addr_in,
   input  logic [31:0] Data_in,
   input  logic [2:0]  dm_ctrl,
   output logic [31:0] Data_out,
   output logic [15:0] led,
   output logic        misalign
);

   localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      SzWord,
      SzHalf,
      SzByte
   } acc_size_e;

   typedef enum logic [1:0] {
      RegLed    = 2'd0,
      RegCycle  = 2'd1,
      RegStores = 2'd2,
      RegStatus = 2'd3
   } mmio_reg_e;

   logic [31:0]     mem_q [DEPTH_WORDS];

   logic [15:0]     led_q, led_d;
   logic [31:0]     cycle_q, cycle_d;
   logic [31:0]     stores_q, stores_d;
   logic            misalign_q, misalign_d;

   acc_size_e       acc_size;
   logic            ext_sign;
   logic            misaligned;
   logic            in_ram;
   logic            in_mmio;
   mmio_reg_e       mmio_sel;
   logic [IdxW-1:0] idx;
   logic [31:0]     ram_word;
   logic [15:0]     half_lane;
   logic [7:0]      byte_lane;
   logic [31:0]     ram_rd;
   logic [31:0]     mmio_rd;
   logic            ram_we;
   logic            mmio_we;
   logic [3:0]      lane_en;
   logic [31:0]     lane_wdata;

   // Access-size decode; unlisted codes behave as word accesses.
   always_comb begin
      acc_size = SzWord;
      ext_sign = 1'b0;
      case (dm_ctrl)
         3'b001: begin
            acc_size = SzHalf;
            ext_sign = 1'b1;
         end
         3'b010: acc_size = SzHalf;
         3'b011: begin
            acc_size = SzByte;
            ext_sign = 1'b1;
         end
         3'b100: acc_size = SzByte;
         default: ;
      endcase
   end

   always_comb begin
      misaligned = 1'b0;
      case (acc_size)
         SzWord:  misaligned = |Addr_in[1:0];
         SzHalf:  misaligned = Addr_in[0];
         default: misaligned = 1'b0;
      endcase
   end

   assign in_ram   = (Addr_in[31:IdxW+2] == '0);
   assign in_mmio  = (Addr_in[31:4] == MMIO_BASE[31:4]);
   assign mmio_sel = mmio_reg_e'(Addr_in[3:2]);
   assign idx      = Addr_in[IdxW+1:2];
   assign ram_word = mem_q[idx];

   // Load path: lane select and extension from the pre-edge RAM word.
   always_comb begin
      half_lane = Addr_in[1] ? ram_word[31:16] : ram_word[15:0];
      byte_lane = ram_word[7:0];
      case (Addr_in[1:0])
         2'd1:    byte_lane = ram_word[15:8];
         2'd2:    byte_lane = ram_word[23:16];
         2'd3:    byte_lane = ram_word[31:24];
         default: byte_lane = ram_word[7:0];
      endcase
      case (acc_size)
         SzHalf:  ram_rd = {{16{ext_sign & half_lane[15]}}, half_lane};
         SzByte:  ram_rd = {{24{ext_sign & byte_lane[7]}}, byte_lane};
         default: ram_rd = ram_word;
      endcase
   end

   always_comb begin
      mmio_rd = '0;
      unique case (mmio_sel)
         RegLed:    mmio_rd = {16'b0, led_q};
         RegCycle:  mmio_rd = cycle_q;
         RegStores: mmio_rd = stores_q;
         RegStatus: mmio_rd = {31'b0, misalign_q};
      endcase
   end

   always_comb begin
      Data_out = '0;
      if (!misaligned) begin
         if (in_ram) begin
            Data_out = ram_rd;
         end else if (in_mmio && acc_size == SzWord) begin
            Data_out = mmio_rd;
         end
      end
   end

   // Store path: lane enables and replicated write data.
   always_comb begin
      lane_en    = 4'b1111;
      lane_wdata = Data_in;
      case (acc_size)
         SzHalf: begin
            lane_en    = Addr_in[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{Data_in[15:0]}};
         end
         SzByte: begin
            lane_en    = 4'b0001 << Addr_in[1:0];
            lane_wdata = {4{Data_in[7:0]}};
         end
         default: ;
      endcase
   end

   assign ram_we  = mem_w & ~misaligned & in_ram;
   assign mmio_we = mem_w & ~misaligned & in_mmio & (acc_size == SzWord);

   always_comb begin
      led_d      = led_q;
      cycle_d    = cycle_q + 32'd1;
      stores_d   = stores_q;
      misalign_d = misalign_q;
      if (ram_we) begin
         stores_d = stores_q + 32'd1;
      end
      if (mmio_we) begin
         case (mmio_sel)
            RegLed:    led_d = Data_in[15:0];
            RegStatus: if (Data_in[0]) misalign_d = 1'b0;
            default: ;
         endcase
      end
      // Out-of-range stores are silently dropped, so only decoded regions raise the flag.
      if (mem_w && misaligned && (in_ram || in_mmio)) begin
         misalign_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         led_q      <= '0;
         cycle_q    <= '0;
         stores_q   <= '0;
         misalign_q <= 1'b0;
      end else begin
         led_q      <= led_d;
         cycle_q    <= cycle_d;
         stores_q   <= stores_d;
         misalign_q <= misalign_d;
      end
   end

   // RAM is never cleared; reset only blocks the store presented in that cycle.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (rst && ram_we && lane_en[b]) begin
            mem_q[idx][8*b +: 8] <= lane_wdata[8*b +: 8];
         end
      end
   end

   assign led      = led_q;
   assign misalign = misalign_q;

endmodule

// File: tb/tb_dm_responder.sv
// Randomised scoreboard bench for dm_responder against a byte-array reference model.
module tb_dm_responder;

   localparam int unsigned DEPTH     = 1024;
   localparam int unsigned RAM_BYTES = DEPTH * 4;
   localparam logic [31:0] MMIO      = 32'hFFFF_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        mem_w = 1'b0;
   logic [31:0] Addr_in = '0;
   logic [31:0] Data_in = '0;
   logic [2:0]  dm_ctrl = '0;
   logic [31:0] Data_out;
   logic [15:0] led;
   logic        misalign;

   always #5 clk = ~clk;

   dm_responder #(
      .DEPTH_WORDS(DEPTH),
      .MMIO_BASE  (MMIO)
   ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .mem_w   (mem_w),
      .Addr_in (Addr_in),
      .Data_in (Data_in),
      .dm_ctrl (dm_ctrl),
      .Data_out(Data_out),
      .led     (led),
      .misalign(misalign)
   );

   typedef struct {
      logic [31:0] data;
      logic [15:0] led;
      logic        mis;
      int          id;
   } exp_t;

   exp_t exp_q[$];

   // Reference state
   logic [7:0]  m_mem [RAM_BYTES];
   logic [15:0] m_led;
   logic [31:0] m_cyc;
   logic [31:0] m_stores;
   logic        m_mis;

   int n_checks = 0;
   int n_fail   = 0;
   int op_id    = 0;

   function automatic int size_of(input logic [2:0] c);
      if (c == 3'd1 || c == 3'd2) return 2;
      if (c == 3'd3 || c == 3'd4) return 1;
      return 4;
   endfunction

   function automatic bit in_mmio(input logic [31:0] a);
      return (a >= MMIO) && (a - MMIO < 32'd16);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] c);
      int          sz;
      bit          sgn;
      logic [31:0] v;
      sz  = size_of(c);
      sgn = (c == 3'd1 || c == 3'd3);
      v   = '0;
      if ((a % 32'(sz)) != 0) return '0;
      if (a < 32'(RAM_BYTES)) begin
         for (int i = 0; i < sz; i++) v = v | (32'(m_mem[a + 32'(i)]) << (8 * i));
         if (sgn && v[8*sz-1]) v = v | (32'hFFFF_FFFF << (8 * sz));
         return v;
      end
      if (in_mmio(a) && sz == 4) begin
         case (a - MMIO)
            32'd0:   return {16'b0, m_led};
            32'd4:   return m_cyc;
            32'd8:   return m_stores;
            default: return {31'b0, m_mis};
         endcase
      end
      return '0;
   endfunction

   function automatic void ref_store(input logic [31:0] a, input logic [31:0] d,
                                     input logic [2:0] c);
      int sz;
      sz = size_of(c);
      if ((a % 32'(sz)) != 0) begin
         if (a < 32'(RAM_BYTES) || in_mmio(a)) m_mis = 1'b1;
         return;
      end
      if (a < 32'(RAM_BYTES)) begin
         for (int i = 0; i < sz; i++) m_mem[a + 32'(i)] = d[8*i +: 8];
         m_stores = m_stores + 32'd1;
      end else if (in_mmio(a) && sz == 4) begin
         if (a - MMIO == 32'd0) m_led = d[15:0];
         if (a - MMIO == 32'd12 && d[0]) m_mis = 1'b0;
      end
   endfunction

   function automatic void check(input string name, input int id, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s op%0d: got %h, expected %h", name, id, act, exp);
      end
   endfunction

   // Monitor: the DUT presents a response every cycle; compare whenever one is expected.
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("data_out", e.id, Data_out, e.data);
         check("led", e.id, 32'(led), 32'(e.led));
         check("misalign", e.id, 32'(misalign), 32'(e.mis));
      end
   end

   task automatic op(input bit we, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] c, input bit chk, input bit has_k = 1'b0,
                     input logic [31:0] k = '0);
      exp_t e;
      mem_w   = we;
      Addr_in = a;
      Data_in = d;
      dm_ctrl = c;
      if (chk) begin
         e.data = has_k ? k : ref_load(a, c);
         e.led  = m_led;
         e.mis  = m_mis;
         e.id   = op_id;
         exp_q.push_back(e);
      end
      op_id++;
      @(posedge clk);
      #1;
      if (we) ref_store(a, d, c);
      m_cyc = m_cyc + 32'd1;
   endtask

   task automatic do_reset(input bit we, input logic [31:0] a, input logic [31:0] d);
      rst     = 1'b0;
      mem_w   = we;
      Addr_in = a;
      Data_in = d;
      dm_ctrl = 3'd0;
      @(posedge clk);
      #1;
      rst      = 1'b1;
      m_led    = '0;
      m_cyc    = '0;
      m_stores = '0;
      m_mis    = 1'b0;
   endtask

   initial begin
      int          sel;
      bit          we;
      logic [2:0]  c;
      logic [31:0] a;

      @(posedge clk);
      #1;
      do_reset(1'b0, '0, '0);

      // Give every byte the random region touches a known value.
      for (int i = 0; i < 64; i++) op(1'b1, 32'(i * 4), $urandom, 3'd0, 1'b0);
      do_reset(1'b0, '0, '0);

      // Counters after reset release
      op(1'b0, MMIO + 32'd4, '0, 3'd0, 1'b1, 1'b1, 32'd0);
      op(1'b0, MMIO + 32'd4, '0, 3'd0, 1'b1, 1'b1, 32'd1);
      op(1'b0, MMIO + 32'd8, '0, 3'd0, 1'b1, 1'b1, 32'd0);
      op(1'b0, MMIO + 32'd0, '0, 3'd0, 1'b1, 1'b1, 32'd0);
      op(1'b0, MMIO + 32'd12, '0, 3'd0, 1'b1, 1'b1, 32'd0);

      // Word round trip
      op(1'b1, 32'h10, 32'h89AB_CDEF, 3'd0, 1'b1);
      op(1'b0, 32'h10, '0, 3'd0, 1'b1, 1'b1, 32'h89AB_CDEF);
      op(1'b0, MMIO + 32'd8, '0, 3'd0, 1'b1, 1'b1, 32'd1);

      // Sub-word stores and extension
      op(1'b1, 32'h21, 32'h0000_0080, 3'd3, 1'b1);
      op(1'b0, 32'h21, '0, 3'd3, 1'b1, 1'b1, 32'hFFFF_FF80);
      op(1'b0, 32'h21, '0, 3'd4, 1'b1, 1'b1, 32'h0000_0080);
      op(1'b1, 32'h22, 32'h0000_8001, 3'd1, 1'b1);
      op(1'b0, 32'h22, '0, 3'd1, 1'b1, 1'b1, 32'hFFFF_8001);
      op(1'b0, 32'h22, '0, 3'd2, 1'b1, 1'b1, 32'h0000_8001);
      op(1'b0, 32'h20, '0, 3'd4, 1'b1);
      op(1'b0, 32'h20, '0, 3'd0, 1'b1);

      // Misalignment and sticky status
      op(1'b0, 32'h30, '0, 3'd0, 1'b1);
      op(1'b1, 32'h31, 32'hCAFE_F00D, 3'd0, 1'b1);
      op(1'b0, 32'h31, '0, 3'd0, 1'b1, 1'b1, 32'd0);
      op(1'b0, 32'h30, '0, 3'd0, 1'b1);
      op(1'b1, MMIO + 32'd12, 32'd0, 3'd0, 1'b1);
      op(1'b0, MMIO + 32'd12, '0, 3'd0, 1'b1, 1'b1, 32'd1);
      op(1'b1, MMIO + 32'd12, 32'd1, 3'd0, 1'b1);
      op(1'b0, MMIO + 32'd12, '0, 3'd0, 1'b1, 1'b1, 32'd0);

      // MMIO LED and CYCLE
      op(1'b1, MMIO, 32'h1234_ABCD, 3'd0, 1'b1);
      op(1'b0, MMIO, '0, 3'd0, 1'b1, 1'b1, 32'h0000_ABCD);
      op(1'b0, MMIO + 32'd4, '0, 3'd0, 1'b1);
      for (int i = 0; i < 4; i++) op(1'b0, 32'h0, '0, 3'd0, 1'b0);
      op(1'b0, MMIO + 32'd4, '0, 3'd0, 1'b1);
      op(1'b1, MMIO + 32'd4, 32'd0, 3'd0, 1'b1);
      op(1'b0, MMIO + 32'd4, '0, 3'd0, 1'b1);

      // Out of range
      op(1'b1, 32'(RAM_BYTES), 32'h5555_AAAA, 3'd0, 1'b1);
      op(1'b0, 32'(RAM_BYTES), '0, 3'd0, 1'b1, 1'b1, 32'd0);
      op(1'b0, MMIO + 32'd8, '0, 3'd0, 1'b1);
      op(1'b0, 32'h0, '0, 3'd0, 1'b1);

      // Random traffic over RAM, MMIO and out-of-range space
      for (int n = 0; n < 600; n++) begin
         sel = $urandom_range(0, 9);
         c   = 3'($urandom_range(0, 7));
         we  = ($urandom_range(0, 9) < 4);
         if (sel < 7) a = 32'($urandom_range(0, 255));
         else if (sel < 9) a = MMIO + 32'($urandom_range(0, 15));
         else a = 32'(RAM_BYTES) + 32'($urandom_range(0, 255));
         if (we && !(a < 32'(RAM_BYTES))) a = a & ~32'(size_of(c) - 1);
         op(we, a, $urandom, c, 1'b1);
      end

      // Reset with a store presented
      op(1'b0, 32'h40, '0, 3'd0, 1'b1);
      do_reset(1'b1, 32'h40, 32'hDEAD_BEEF);
      op(1'b0, MMIO + 32'd4, '0, 3'd0, 1'b1, 1'b1, 32'd0);
      op(1'b0, MMIO + 32'd8, '0, 3'd0, 1'b1, 1'b1, 32'd0);
      op(1'b0, MMIO + 32'd0, '0, 3'd0, 1'b1, 1'b1, 32'd0);
      op(1'b0, MMIO + 32'd12, '0, 3'd0, 1'b1, 1'b1, 32'd0);
      op(1'b0, 32'h40, '0, 3'd0, 1'b1);
      op(1'b0, 32'h10, '0, 3'd0, 1'b1);

      mem_w = 1'b0;
      repeat (2) @(posedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
